// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control unit: one Moore FSM sequences fetch, decode,
// address/execute, memory and writeback steps. Each instruction takes
// 3 to 5 states plus any memory wait cycles. Write enables are forced low
// while rst_n is asserted.
module multicycle_controller #(
  parameter int XLEN     = 64,
  parameter int WORD_OPS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       adr_src,
  output logic       is_lui,
  output logic       is_word,
  output logic       illegal_inst,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic [3:0] state
);

  // RV64 word opcodes only exist on a 64-bit datapath.
  localparam bit WORD_EN = (XLEN == 64) && (WORD_OPS != 0);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_UTYPE    = 4'd12;
  localparam logic [3:0] S_TRAP     = 4'd13;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  logic [3:0] next_state;
  logic       pc_we;
  logic       ir_we;
  logic       mem_we;
  logic       reg_we;

  // Immediate format implied by the opcode; valid in every state.
  function automatic logic [2:0] imm_of(input logic [6:0] op);
    logic [2:0] r;
    case (op)
      OP_LOAD, OP_IMM, OP_JALR, OP_IMM32: r = IMM_I;
      OP_STORE:                           r = IMM_S;
      OP_BRANCH:                          r = IMM_B;
      OP_JAL:                             r = IMM_J;
      OP_AUIPC, OP_LUI:                   r = IMM_U;
      default:                            r = 3'b000;
    endcase
    return r;
  endfunction

  // State register; reset returns to FETCH without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  // Instruction flags captured when leaving DECODE, held for the whole instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_lui  <= 1'b0;
      is_word <= 1'b0;
    end else if (state == S_DECODE) begin
      is_lui  <= (opcode == OP_LUI);
      is_word <= WORD_EN && ((opcode == OP_REG32) || (opcode == OP_IMM32));
    end
  end

  // Next-state sequencing; unused codes and TRAP fall into TRAP.
  always_comb begin
    next_state = S_TRAP;
    case (state)
      S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_REG:            next_state = S_EXECR;
          OP_IMM:            next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_AUIPC, OP_LUI:  next_state = S_UTYPE;
          OP_REG32:          next_state = WORD_EN ? S_EXECR : S_TRAP;
          OP_IMM32:          next_state = WORD_EN ? S_EXECI : S_TRAP;
          default:           next_state = S_TRAP;
        endcase
      end
      S_MEMADR:   next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    next_state = S_ALUWB;
      S_EXECI:    next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JALR:     next_state = S_JAL;
      S_JAL:      next_state = S_ALUWB;
      S_UTYPE:    next_state = S_ALUWB;
      default:    next_state = S_TRAP;
    endcase
  end

  // Moore output decode; FETCH and BRANCH also look at mem_ready / branch_taken.
  always_comb begin
    pc_we        = 1'b0;
    ir_we        = 1'b0;
    mem_read     = 1'b0;
    mem_we       = 1'b0;
    reg_we       = 1'b0;
    adr_src      = 1'b0;
    illegal_inst = 1'b0;
    result_src   = 2'b00;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    imm_src      = imm_of(opcode);
    case (state)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_we      = mem_ready;
        ir_we      = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = IMM_B;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        adr_src  = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_we     = 1'b1;
      end
      S_MEMWRITE: begin
        mem_we  = 1'b1;
        adr_src = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: reg_we = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_we     = branch_taken;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_JAL: begin
        pc_we     = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_UTYPE: begin
        alu_src_a = is_lui ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
      end
      S_TRAP: illegal_inst = 1'b1;
      default: ;
    endcase
  end

  // Architectural write enables are suppressed for as long as reset is held.
  assign pc_write  = pc_we  & rst_n;
  assign ir_write  = ir_we  & rst_n;
  assign mem_write = mem_we & rst_n;
  assign reg_write = reg_we & rst_n;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboarded bench for multicycle_controller: a 64-bit and a 32-bit
// instance share stimulus; per-cycle expectations come from an
// instruction-level model of the state sequence each opcode walks through.
module tb_multicycle_controller;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3,
                 ST_MEMWB = 4, ST_MEMWRITE = 5, ST_EXECR = 6, ST_EXECI = 7,
                 ST_ALUWB = 8, ST_BRANCH = 9, ST_JAL = 10, ST_JALR = 11,
                 ST_UTYPE = 12, ST_TRAP = 13;

  localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011,
                         OPC_REG = 7'b0110011, OPC_IMM = 7'b0010011,
                         OPC_BRANCH = 7'b1100011, OPC_JAL = 7'b1101111,
                         OPC_JALR = 7'b1100111, OPC_AUIPC = 7'b0010111,
                         OPC_LUI = 7'b0110111, OPC_IMM32 = 7'b0011011,
                         OPC_REG32 = 7'b0111011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic branch_taken = 1'b0;
  logic mem_ready = 1'b0;

  logic a_pc_write, a_ir_write, a_mem_read, a_mem_write, a_reg_write, a_adr_src;
  logic a_is_lui, a_is_word, a_illegal;
  logic [1:0] a_result_src, a_alu_src_a, a_alu_src_b, a_alu_op;
  logic [2:0] a_imm_src;
  logic [3:0] a_state;
  logic b_pc_write, b_ir_write, b_mem_read, b_mem_write, b_reg_write, b_adr_src;
  logic b_is_lui, b_is_word, b_illegal;
  logic [1:0] b_result_src, b_alu_src_a, b_alu_src_b, b_alu_op;
  logic [2:0] b_imm_src;
  logic [3:0] b_state;

  multicycle_controller #(.XLEN(64), .WORD_OPS(1)) dut64 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .pc_write(a_pc_write), .ir_write(a_ir_write),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .reg_write(a_reg_write),
    .adr_src(a_adr_src), .is_lui(a_is_lui), .is_word(a_is_word),
    .illegal_inst(a_illegal), .result_src(a_result_src), .alu_src_a(a_alu_src_a),
    .alu_src_b(a_alu_src_b), .alu_op(a_alu_op), .imm_src(a_imm_src), .state(a_state)
  );

  multicycle_controller #(.XLEN(32), .WORD_OPS(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .pc_write(b_pc_write), .ir_write(b_ir_write),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .reg_write(b_reg_write),
    .adr_src(b_adr_src), .is_lui(b_is_lui), .is_word(b_is_word),
    .illegal_inst(b_illegal), .result_src(b_result_src), .alu_src_a(b_alu_src_a),
    .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .imm_src(b_imm_src), .state(b_state)
  );

  // Output bundle layout: state, imm_src, alu_op, src_a, src_b, result_src,
  // pc_write, ir_write, mem_read, mem_write, reg_write, adr_src, is_lui, is_word, illegal.
  logic [23:0] act64, act32;
  assign act64 = {a_state, a_imm_src, a_alu_op, a_alu_src_a, a_alu_src_b, a_result_src,
                  a_pc_write, a_ir_write, a_mem_read, a_mem_write, a_reg_write,
                  a_adr_src, a_is_lui, a_is_word, a_illegal};
  assign act32 = {b_state, b_imm_src, b_alu_op, b_alu_src_a, b_alu_src_b, b_result_src,
                  b_pc_write, b_ir_write, b_mem_read, b_mem_write, b_reg_write,
                  b_adr_src, b_is_lui, b_is_word, b_illegal};

  typedef struct {
    logic [23:0] e64;
    logic [23:0] e32;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  typedef int path_t[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic l64 = 1'b0, w64 = 1'b0, l32 = 1'b0, w32 = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    if (op == OPC_LOAD || op == OPC_IMM || op == OPC_JALR || op == OPC_IMM32) return 3'b000;
    if (op == OPC_STORE) return 3'b001;
    if (op == OPC_BRANCH) return 3'b010;
    if (op == OPC_JAL) return 3'b011;
    if (op == OPC_AUIPC || op == OPC_LUI) return 3'b100;
    return 3'b000;
  endfunction

  // Expected outputs for one cycle spent in step `st` of an instruction.
  function automatic logic [23:0] model(input int st, input logic [6:0] op, input logic mr,
                                        input logic bt, input logic lui, input logic wrd,
                                        input logic in_rst);
    logic [2:0] imm;
    logic [1:0] aop, sa, sbv, rs;
    logic pc, ir, mrd, mwr, rw, adr, ill;
    logic [3:0] s4;
    imm = imm_of(op);
    {aop, sa, sbv, rs} = 8'h00;
    {pc, ir, mrd, mwr, rw, adr, ill} = 7'b0;
    s4 = 4'(st);
    case (st)
      ST_FETCH:    begin mrd = 1; sbv = 2'b10; rs = 2'b10; pc = mr; ir = mr; end
      ST_DECODE:   begin sa = 2'b01; sbv = 2'b01; imm = 3'b010; end
      ST_MEMADR:   begin sa = 2'b10; sbv = 2'b01; end
      ST_MEMREAD:  begin mrd = 1; adr = 1; end
      ST_MEMWB:    begin rs = 2'b01; rw = 1; end
      ST_MEMWRITE: begin mwr = 1; adr = 1; end
      ST_EXECR:    begin sa = 2'b10; sbv = 2'b00; aop = 2'b10; end
      ST_EXECI:    begin sa = 2'b10; sbv = 2'b01; aop = 2'b10; end
      ST_ALUWB:    rw = 1;
      ST_BRANCH:   begin sa = 2'b10; aop = 2'b01; pc = bt; end
      ST_JALR:     begin sa = 2'b10; sbv = 2'b01; end
      ST_JAL:      begin pc = 1; sa = 2'b01; sbv = 2'b10; end
      ST_UTYPE:    begin sa = (op == OPC_LUI) ? 2'b11 : 2'b01; sbv = 2'b01; end
      ST_TRAP:     ill = 1;
      default: ;
    endcase
    if (in_rst) begin pc = 0; ir = 0; mwr = 0; rw = 0; end
    return {s4, imm, aop, sa, sbv, rs, pc, ir, mrd, mwr, rw, adr, lui, wrd, ill};
  endfunction

  // Step sequence of one instruction; each entry is step*2 + mem_ready to drive.
  function automatic path_t build_path(input logic [6:0] op, input bit wen,
                                       input int fw, input int mw);
    path_t p;
    for (int k = 0; k < fw; k++) p.push_back(ST_FETCH * 2);
    p.push_back(ST_FETCH * 2 + 1);
    p.push_back(ST_DECODE * 2 + int'($urandom_range(1)));
    if (op == OPC_LOAD || op == OPC_STORE) begin
      int ws = (op == OPC_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
      p.push_back(ST_MEMADR * 2 + int'($urandom_range(1)));
      for (int k = 0; k < mw; k++) p.push_back(ws * 2);
      p.push_back(ws * 2 + 1);
      if (op == OPC_LOAD) p.push_back(ST_MEMWB * 2 + int'($urandom_range(1)));
    end else begin
      path_t body;
      case (op)
        OPC_REG:            body = '{ST_EXECR, ST_ALUWB};
        OPC_IMM:            body = '{ST_EXECI, ST_ALUWB};
        OPC_BRANCH:         body = '{ST_BRANCH};
        OPC_JAL:            body = '{ST_JAL, ST_ALUWB};
        OPC_JALR:           body = '{ST_JALR, ST_JAL, ST_ALUWB};
        OPC_AUIPC, OPC_LUI: body = '{ST_UTYPE, ST_ALUWB};
        OPC_REG32:          if (wen) body = '{ST_EXECR, ST_ALUWB}; else body = '{ST_TRAP};
        OPC_IMM32:          if (wen) body = '{ST_EXECI, ST_ALUWB}; else body = '{ST_TRAP};
        default:            body = '{ST_TRAP};
      endcase
      foreach (body[k]) p.push_back(body[k] * 2 + int'($urandom_range(1)));
    end
    return p;
  endfunction

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      @(posedge clk); #1;
      cyc++;
      rst_n = 1'b0;
      mem_ready = 1'b1;
      branch_taken = 1'($urandom_range(1));
      opcode = 7'($urandom);
      #1;
      checks++;
      if (a_state !== 4'd0 || b_state !== 4'd0 || a_mem_write !== 1'b0 ||
          b_mem_write !== 1'b0 || a_ir_write !== 1'b0 || a_pc_write !== 1'b0) begin
        errors++;
        $display("FAIL async_reset cyc %0d got state64=%0d state32=%0d mw64=%b mw32=%b ir64=%b pc64=%b want 0 0 0 0 0 0",
                 cyc, a_state, b_state, a_mem_write, b_mem_write, a_ir_write, a_pc_write);
      end
      e.e64 = model(ST_FETCH, opcode, 1'b1, branch_taken, 1'b0, 1'b0, 1'b1);
      e.e32 = e.e64;
      e.cyc = cyc;
      sb.push_back(e);
    end
    {l64, w64, l32, w32} = 4'b0;
  endtask

  // bt < 0 randomizes branch_taken each cycle; abort_at >= 0 resets at that step.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                           input int bt, input int abort_at);
    path_t p64, p32;
    bit trapped;
    int n;
    p64 = build_path(op, 1'b1, fw, mw);
    p32 = build_path(op, 1'b0, fw, mw);
    trapped = ((p64[p64.size()-1] >> 1) == ST_TRAP) || ((p32[p32.size()-1] >> 1) == ST_TRAP);
    while (p32.size() < p64.size()) p32.push_back(ST_TRAP * 2);
    while (p64.size() < p32.size()) p64.push_back(ST_TRAP * 2);
    if (trapped && abort_at < 0) begin
      int last64 = p64[p64.size()-1] >> 1;
      for (int k = 0; k < 9; k++) begin
        p64.push_back(((last64 == ST_TRAP) ? ST_TRAP : ST_FETCH) * 2);
        p32.push_back(ST_TRAP * 2);
      end
    end
    n = p64.size();
    if (abort_at >= 0 && abort_at < n) n = abort_at;
    for (int i = 0; i < n; i++) begin
      exp_t e;
      int s64, s32;
      @(posedge clk); #1;
      cyc++;
      rst_n = 1'b1;
      opcode = op;
      mem_ready = 1'(p64[i] & 1);
      branch_taken = (bt < 0) ? 1'($urandom_range(1)) : 1'(bt);
      s64 = p64[i] >> 1;
      s32 = p32[i] >> 1;
      e.e64 = model(s64, op, mem_ready, branch_taken, l64, w64, 1'b0);
      e.e32 = model(s32, op, mem_ready, branch_taken, l32, w32, 1'b0);
      e.cyc = cyc;
      sb.push_back(e);
      if (s64 == ST_DECODE) begin
        l64 = (op == OPC_LUI);
        w64 = (op == OPC_REG32) || (op == OPC_IMM32);
      end
      if (s32 == ST_DECODE) begin
        l32 = (op == OPC_LUI);
        w32 = 1'b0;
      end
    end
    if (trapped || abort_at >= 0) do_reset(2);
  endtask

  // Monitor: one expected record per clock, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (act64 !== e.e64) begin
          errors++;
          $display("FAIL outputs_xlen64 cyc %0d got %h want %h", e.cyc, act64, e.e64);
        end
        checks++;
        if (act32 !== e.e32) begin
          errors++;
          $display("FAIL outputs_xlen32 cyc %0d got %h want %h", e.cyc, act32, e.e32);
        end
      end
    end
  end

  logic [6:0] legal_ops[11] = '{OPC_LOAD, OPC_STORE, OPC_REG, OPC_IMM, OPC_BRANCH, OPC_JAL,
                                OPC_JALR, OPC_AUIPC, OPC_LUI, OPC_IMM32, OPC_REG32};

  initial begin
    do_reset(3);
    run_instr(OPC_LOAD, 2, 2, -1, -1);
    run_instr(OPC_REG, 0, 0, -1, -1);
    run_instr(OPC_BRANCH, 0, 0, 1, -1);
    run_instr(OPC_BRANCH, 1, 0, 0, -1);
    run_instr(OPC_JALR, 0, 0, -1, -1);
    run_instr(OPC_LUI, 0, 0, -1, -1);
    run_instr(OPC_AUIPC, 1, 0, -1, -1);
    run_instr(OPC_REG32, 0, 0, -1, -1);
    run_instr(OPC_IMM32, 0, 0, -1, -1);
    run_instr(OPC_STORE, 0, 6, -1, 5);
    run_instr(OPC_STORE, 1, 1, -1, -1);
    run_instr(7'b1111111, 0, 0, -1, -1);
    for (int t = 0; t < 120; t++) begin
      logic [6:0] op;
      int ab;
      if ($urandom_range(7) == 0) op = 7'($urandom);
      else op = legal_ops[$urandom_range(10)];
      ab = ($urandom_range(9) == 0) ? int'($urandom_range(8)) : -1;
      run_instr(op, int'($urandom_range(2)), int'($urandom_range(3)), -1, ab);
    end
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
